// File: rtl/qkd_tx_qubit_sequencer.sv
// BB84 Alice transmit sequencer: streams LFSR (bit, basis) pairs, then registers the basis-match mask.
// Optional build macro QKD_SIFT_COUNT_EN adds the registered match_count popcount output.
`default_nettype none

module qkd_tx_qubit_sequencer #(
    parameter int          N_SLOTS = 80,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               qb_valid,
    input  logic               qb_ready,
    output logic               qb_bit,
    output logic               qb_basis,
    input  logic [N_SLOTS-1:0] bob_basis,
    input  logic               bob_basis_valid,
    output logic [N_SLOTS-1:0] alice_bits,
    output logic [N_SLOTS-1:0] basis_match,
    output logic               busy,
    output logic               done
`ifdef QKD_SIFT_COUNT_EN
    ,
    output logic [$clog2(N_SLOTS+1)-1:0] match_count
`endif
);

    localparam int              IW       = $clog2(N_SLOTS);
    localparam logic [15:0]     SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [IW-1:0]   LAST_IDX = IW'(N_SLOTS - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SEND       = 2'd1,
        WAIT_BASIS = 2'd2,
        DONE       = 2'd3
    } state_t;

    state_t             state;
    logic [15:0]        lfsr;
    logic [15:0]        lfsr_next;
    logic [IW-1:0]      idx;
    logic [N_SLOTS-1:0] alice_basis;
    logic [N_SLOTS-1:0] match_next;
    logic               accept;

    // x^16+x^14+x^13+x^11+1, shifting left with feedback into bit 0
    assign lfsr_next  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign accept     = qb_valid & qb_ready;
    assign match_next = ~(alice_basis ^ bob_basis);

`ifdef QKD_SIFT_COUNT_EN
    localparam int CW = $clog2(N_SLOTS + 1);

    function automatic logic [CW-1:0] popcount(input logic [N_SLOTS-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            lfsr        <= SEED_EFF;
            idx         <= '0;
            qb_valid    <= 1'b0;
            qb_bit      <= 1'b0;
            qb_basis    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            alice_bits  <= '0;
            alice_basis <= '0;
            basis_match <= '0;
`ifdef QKD_SIFT_COUNT_EN
            match_count <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= SEND;
                        idx      <= '0;
                        qb_valid <= 1'b1;
                        busy     <= 1'b1;
                        qb_bit   <= lfsr[0];
                        qb_basis <= lfsr[15];
                    end
                end
                SEND: begin
                    if (accept) begin
                        alice_bits[idx]  <= qb_bit;
                        alice_basis[idx] <= qb_basis;
                        lfsr             <= lfsr_next;
                        if (idx == LAST_IDX) begin
                            state    <= WAIT_BASIS;
                            qb_valid <= 1'b0;
                            qb_bit   <= 1'b0;
                            qb_basis <= 1'b0;
                        end else begin
                            idx      <= idx + IW'(1);
                            qb_bit   <= lfsr_next[0];
                            qb_basis <= lfsr_next[15];
                        end
                    end
                end
                WAIT_BASIS: begin
                    if (bob_basis_valid) begin
                        state       <= DONE;
                        basis_match <= match_next;
                        done        <= 1'b1;
                        busy        <= 1'b0;
`ifdef QKD_SIFT_COUNT_EN
                        match_count <= popcount(match_next);
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_qkd_tx_qubit_sequencer.sv
// Directed self-checking bench for qkd_tx_qubit_sequencer with a software LFSR model.
`default_nettype none

module tb_qkd_tx_qubit_sequencer;

    localparam int N = 80;
    localparam int CW = $clog2(N + 1);

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         qb_ready = 1'b0;
    logic [N-1:0] bob_basis = '0;
    logic         bob_basis_valid = 1'b0;
    wire          qb_valid, qb_bit, qb_basis, busy, done;
    wire  [N-1:0] alice_bits, basis_match;
    logic         start0 = 1'b0;
    wire          qb_valid0, qb_bit0, qb_basis0, busy0, done0;
    wire  [N-1:0] alice_bits0, basis_match0;
`ifdef QKD_SIFT_COUNT_EN
    wire [CW-1:0] match_count, match_count0;
`endif

    qkd_tx_qubit_sequencer #(.N_SLOTS(N), .SEED(16'hACE1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .qb_valid(qb_valid), .qb_ready(qb_ready), .qb_bit(qb_bit), .qb_basis(qb_basis),
        .bob_basis(bob_basis), .bob_basis_valid(bob_basis_valid),
        .alice_bits(alice_bits), .basis_match(basis_match), .busy(busy), .done(done)
`ifdef QKD_SIFT_COUNT_EN
        , .match_count(match_count)
`endif
    );

    qkd_tx_qubit_sequencer #(.N_SLOTS(N), .SEED(16'h0000)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0),
        .qb_valid(qb_valid0), .qb_ready(qb_ready), .qb_bit(qb_bit0), .qb_basis(qb_basis0),
        .bob_basis(bob_basis), .bob_basis_valid(bob_basis_valid),
        .alice_bits(alice_bits0), .basis_match(basis_match0), .busy(busy0), .done(done0)
`ifdef QKD_SIFT_COUNT_EN
        , .match_count(match_count0)
`endif
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           passes = 0;
    logic [15:0]  m_lfsr;
    logic [N-1:0] cap_bits, cap_basis;

    function automatic logic [15:0] lstep(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (qb_valid !== 1'b1 || busy !== 1'b1)
            $display("FAIL frame_start: valid=%b busy=%b, required 1 1", qb_valid, busy);
        else passes++;
    endtask

    // Drives nbeats accepted beats; every visible pair must match the model (stable across stalls).
    task automatic run_frame(input int nbeats, input bit bp, input bit abuse, input bit chk_cycles);
        int  beats = 0;
        int  cycles = 0;
        int  bad = 0;
        logic rdy;
        while (beats < nbeats && cycles < 1000) begin
            if (qb_valid !== 1'b1 || qb_bit !== m_lfsr[0] || qb_basis !== m_lfsr[15]) begin
                if (bad == 0)
                    $display("FAIL beat_pair: beat %0d valid=%b pair=(%b,%b), required 1 (%b,%b)",
                             beats, qb_valid, qb_bit, qb_basis, m_lfsr[0], m_lfsr[15]);
                bad++;
            end
            if (abuse && beats == 10) begin
                start = 1'b1;
                bob_basis_valid = 1'b1;
            end
            rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            qb_ready = rdy;
            tick();
            start = 1'b0;
            bob_basis_valid = 1'b0;
            cycles++;
            if (rdy) begin
                cap_bits[beats]  = m_lfsr[0];
                cap_basis[beats] = m_lfsr[15];
                m_lfsr = lstep(m_lfsr);
                beats++;
            end
        end
        qb_ready = 1'b0;
        checks++;
        if (bad != 0 || beats != nbeats)
            $display("FAIL frame_beats: beats=%0d bad_pairs=%0d, required %0d and 0", beats, bad, nbeats);
        else passes++;
        if (chk_cycles) begin
            checks++;
            if (cycles != N) $display("FAIL no_bubbles: cycles=%0d, required %0d", cycles, N);
            else passes++;
        end
        if (nbeats == N) begin
            checks++;
            if (qb_valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0)
                $display("FAIL end_of_send: valid=%b busy=%b done=%b, required 0 1 0", qb_valid, busy, done);
            else passes++;
            checks++;
            if (alice_bits !== cap_bits)
                $display("FAIL alice_bits: got %h, required %h", alice_bits, cap_bits);
            else passes++;
        end
    endtask

    task automatic finish_frame(input logic [N-1:0] bob, input logic [N-1:0] exp_mask, input bit b2b);
        bob_basis = bob;
        bob_basis_valid = 1'b1;
        tick();
        bob_basis_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || basis_match !== exp_mask)
            $display("FAIL completion: done=%b busy=%b mask=%h, required 1 0 %h", done, busy, basis_match, exp_mask);
        else passes++;
`ifdef QKD_SIFT_COUNT_EN
        checks++;
        if (match_count !== CW'($countones(exp_mask)))
            $display("FAIL match_count: got %0d, required %0d", match_count, $countones(exp_mask));
        else passes++;
`endif
        if (b2b) start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || basis_match !== exp_mask || qb_valid !== b2b)
            $display("FAIL post_done: done=%b mask=%h valid=%b, required 0 %h %b", done, basis_match, qb_valid, exp_mask, b2b);
        else passes++;
    endtask

    task automatic test_reset();
        checks++;
        if (qb_valid !== 0 || qb_bit !== 0 || qb_basis !== 0 || busy !== 0 || done !== 0 ||
            alice_bits !== '0 || basis_match !== '0)
            $display("FAIL reset_state: valid=%b bit=%b basis=%b busy=%b done=%b bits=%h mask=%h, required all 0",
                     qb_valid, qb_bit, qb_basis, busy, done, alice_bits, basis_match);
        else passes++;
`ifdef QKD_SIFT_COUNT_EN
        checks++;
        if (match_count !== '0) $display("FAIL reset_count: got %0d, required 0", match_count);
        else passes++;
`endif
    endtask

    task automatic test_full_frame();
        pulse_start();
        checks++;
        if (qb_bit !== 1'b1 || qb_basis !== 1'b1)
            $display("FAIL first_pair: (%b,%b), required (1,1)", qb_bit, qb_basis);
        else passes++;
        run_frame(N, 1'b0, 1'b0, 1'b1);
        finish_frame(cap_basis, {N{1'b1}}, 1'b0);
    endtask

    task automatic test_mismatch();
        pulse_start();
        run_frame(N, 1'b0, 1'b0, 1'b0);
        finish_frame(~cap_basis, '0, 1'b0);
        pulse_start();
        run_frame(N, 1'b0, 1'b0, 1'b0);
        finish_frame(cap_basis ^ {40{2'b10}}, {40{2'b01}}, 1'b0);
    endtask

    task automatic test_backpressure();
        pulse_start();
        run_frame(N, 1'b1, 1'b0, 1'b0);
        finish_frame(cap_basis, {N{1'b1}}, 1'b0);
    endtask

    task automatic test_protocol_abuse();
        pulse_start();
        run_frame(N, 1'b0, 1'b1, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        checks++;
        if (qb_valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0)
            $display("FAIL wait_ignores_start: valid=%b busy=%b done=%b, required 0 1 0", qb_valid, busy, done);
        else passes++;
        finish_frame(cap_basis ^ {40{2'b10}}, {40{2'b01}}, 1'b0);
    endtask

    task automatic test_back_to_back();
        pulse_start();
        run_frame(N, 1'b0, 1'b0, 1'b0);
        finish_frame(cap_basis, {N{1'b1}}, 1'b1);
        run_frame(N, 1'b0, 1'b0, 1'b0);
        finish_frame(~cap_basis, '0, 1'b0);
    endtask

    task automatic test_reset_mid_send();
        pulse_start();
        run_frame(37, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        test_reset();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || qb_valid !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_idle: busy=%b valid=%b done=%b, required 0 0 0", busy, qb_valid, done);
        else passes++;
        m_lfsr = 16'hACE1;
        pulse_start();
        checks++;
        if (qb_bit !== 1'b1 || qb_basis !== 1'b1)
            $display("FAIL reseed_pair: (%b,%b), required (1,1)", qb_bit, qb_basis);
        else passes++;
        run_frame(N, 1'b0, 1'b0, 1'b0);
        finish_frame(cap_basis, {N{1'b1}}, 1'b0);
    endtask

    task automatic test_zero_seed();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        checks++;
        if (qb_valid0 !== 1'b1 || qb_bit0 !== 1'b1 || qb_basis0 !== 1'b0)
            $display("FAIL zero_seed_pair: valid=%b (%b,%b), required 1 (1,0)", qb_valid0, qb_bit0, qb_basis0);
        else passes++;
    endtask

    initial begin
        m_lfsr = 16'hACE1;
        cap_bits = '0;
        cap_basis = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_full_frame();
        test_mismatch();
        test_backpressure();
        test_protocol_abuse();
        test_back_to_back();
        test_reset_mid_send();
        test_zero_seed();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
